// File: rtl/timer_arb_pkg.sv
// Shared types for the timer arbiter: slot FSM encoding and watchdog sizing.
package timer_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    COOL = 2'd3
  } state_e;

  // Watchdog is N+WD_EXTRA bits wide so load+WDOG can never wrap.
  localparam int WD_EXTRA = 4;

endpackage

// File: rtl/timer_arbiter_rr.sv
// Combinational round-robin picker: first request at or after ptr, wrapping modulo R.
module rr_arbiter #(
  parameter int R     = 4,
  parameter int PTR_W = (R > 1) ? $clog2(R) : 1
) (
  input  logic [R-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [R-1:0]     gnt,
  output logic [PTR_W-1:0] idx,
  output logic             any
);

  always_comb begin
    logic [PTR_W-1:0] j;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = '0;
    for (int k = 0; k < R; k++) begin
      j = PTR_W'((int'(ptr) + k) % R);
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

endmodule

// File: rtl/timer_arbiter.sv
// Round-robin owner of a single shared one-shot timer, with a per-slot watchdog.
module timer_arbiter
  import timer_arb_pkg::*;
#(
  parameter int N    = 5,
  parameter int R    = 4,
  parameter int WDOG = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [R-1:0]   req,
  input  logic [R*N-1:0] load_in,
  output logic [R-1:0]   gnt,
  output logic [R-1:0]   done,
  output logic [R-1:0]   err,
  output logic           busy,
  output logic [N-1:0]   tmr_load,
  output logic           tmr_trig,
  input  logic           tmr_pulse
);

  localparam int PTR_W = (R > 1) ? $clog2(R) : 1;
  localparam int WD_W  = N + WD_EXTRA;

  state_e           state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] owner_q, owner_d;
  logic [WD_W-1:0]  wdog_q, wdog_d;
  logic [WD_W-1:0]  wd_limit;

  logic [R-1:0]     gnt_d, done_d, err_d;
  logic [N-1:0]     load_d;
  logic             trig_d, busy_d;

  logic [R-1:0]     arb_gnt;
  logic [PTR_W-1:0] arb_idx;
  logic             arb_any;

  rr_arbiter #(
    .R     (R),
    .PTR_W (PTR_W)
  ) u_rr (
    .req (req),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  assign wd_limit = WD_W'(tmr_load) + WD_W'(WDOG);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    wdog_d  = wdog_q;
    gnt_d   = gnt;
    load_d  = tmr_load;
    done_d  = '0;
    err_d   = '0;
    trig_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          state_d = LOAD;
          gnt_d   = arb_gnt;
          owner_d = arb_idx;
          load_d  = load_in[int'(arb_idx)*N +: N];
          ptr_d   = (int'(arb_idx) == R - 1) ? '0 : arb_idx + PTR_W'(1);
        end
      end
      LOAD: begin
        wdog_d = '0;
        if (tmr_load == '0) begin
          // Zero delay never touches the timer.
          done_d[owner_q] = 1'b1;
          gnt_d           = '0;
          state_d         = COOL;
        end else begin
          trig_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        // Priority: timer pulse, then watchdog expiry, then owner abort.
        if (tmr_pulse) begin
          done_d[owner_q] = 1'b1;
          gnt_d           = '0;
          state_d         = COOL;
        end else if (wdog_q == wd_limit) begin
          err_d[owner_q] = 1'b1;
          gnt_d          = '0;
          state_d        = COOL;
        end else if (!req[owner_q]) begin
          gnt_d   = '0;
          state_d = COOL;
        end else begin
          trig_d = 1'b1;
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      COOL: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      wdog_q   <= '0;
      gnt      <= '0;
      done     <= '0;
      err      <= '0;
      busy     <= 1'b0;
      tmr_load <= '0;
      tmr_trig <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      wdog_q   <= wdog_d;
      gnt      <= gnt_d;
      done     <= done_d;
      err      <= err_d;
      busy     <= busy_d;
      tmr_load <= load_d;
      tmr_trig <= trig_d;
    end
  end

endmodule

// File: tb/tb_timer_arbiter.sv
// Randomized scoreboard bench for timer_arbiter with a behavioural one-shot timer.
module tb_timer_arbiter;

  localparam int N    = 5;
  localparam int R    = 4;
  localparam int WDOG = 8;

  localparam int K_DONE  = 0;
  localparam int K_ERR   = 1;
  localparam int K_ABORT = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [R-1:0]   req = '0;
  logic [R*N-1:0] load_in = '0;
  logic [R-1:0]   gnt, done, err;
  logic           busy;
  logic [N-1:0]   tmr_load;
  logic           tmr_trig;
  logic           tmr_pulse = 1'b0;

  always #5 clk = ~clk;

  timer_arbiter #(.N(N), .R(R), .WDOG(WDOG)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .load_in   (load_in),
    .gnt       (gnt),
    .done      (done),
    .err       (err),
    .busy      (busy),
    .tmr_load  (tmr_load),
    .tmr_trig  (tmr_trig),
    .tmr_pulse (tmr_pulse)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    int idx;
    int load;
    int kind;
    int abort_k;
  } exp_t;

  exp_t exp_q[$];

  // Per-requester environment behaviour for the current round.
  int tgt[R];
  bit hang[R];
  int abort_k[R];
  int drv_cnt[R];
  int cfg_load[R];
  int cfg_mode[R];
  int model_ptr = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic int oh2idx(input logic [R-1:0] v);
    for (int i = 0; i < R; i++) if (v[i]) return i;
    return 0;
  endfunction

  // One-shot timer: pulses for one cycle in the target-th trigger-high cycle (0-based).
  logic [7:0] tcnt = '0;
  always @(posedge clk) begin
    if (!tmr_trig) begin
      tcnt      <= '0;
      tmr_pulse <= 1'b0;
    end else begin
      tcnt      <= tcnt + 8'd1;
      tmr_pulse <= !hang[oh2idx(gnt)] && (int'(tcnt) + 1 == tgt[oh2idx(gnt)]);
    end
  end

  // Monitor / scoreboard.
  bit           mon_have = 0;
  exp_t         mon_cur;
  bit           mon_seen = 0;
  int           mon_tc = 0;
  int           mon_age = 0;
  logic [R-1:0] mon_pg = '0;
  logic         mon_pt = 1'b0, mon_pb = 1'b0, mon_pp = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        mon_have = 0; mon_seen = 0; mon_tc = 0; mon_age = 0;
        mon_pg = '0; mon_pt = 1'b0; mon_pb = 1'b0; mon_pp = 1'b0;
      end else begin
        if (gnt != '0 && mon_pg == '0) begin
          if (exp_q.size() == 0) begin
            chk("spurious_grant", 64'(gnt), 64'd0);
          end else begin
            mon_cur = exp_q.pop_front();
            chk("grant_onehot", 64'(gnt), 64'd1 << mon_cur.idx);
            chk("grant_load", 64'(tmr_load), 64'(mon_cur.load));
            mon_have = 1; mon_seen = 0; mon_tc = 0; mon_age = 0;
          end
        end else if (gnt != '0) begin
          mon_age++;
        end
        if (tmr_trig && !mon_pt) chk("trig_latency", 64'(mon_age), 64'd1);
        if (tmr_trig) mon_tc++;
        if (done != '0) begin
          if (!mon_have) chk("spurious_done", 64'(done), 64'd0);
          else begin
            chk("done_owner", 64'(done), 64'd1 << mon_cur.idx);
            chk("done_kind", 64'(K_DONE), 64'(mon_cur.kind));
            if (mon_cur.load != 0) chk("pulse_to_done", 64'(mon_pp), 64'd1);
            else chk("zero_load_no_trig", 64'(mon_tc), 64'd0);
            mon_seen = 1;
          end
        end
        if (err != '0) begin
          if (!mon_have) chk("spurious_err", 64'(err), 64'd0);
          else begin
            chk("err_owner", 64'(err), 64'd1 << mon_cur.idx);
            chk("err_kind", 64'(K_ERR), 64'(mon_cur.kind));
            chk("err_run_cycles", 64'(mon_tc), 64'(mon_cur.load + WDOG + 1));
            mon_seen = 1;
          end
        end
        if (mon_pb && !busy && mon_have) begin
          chk("slot_result_seen", 64'(mon_seen), 64'(mon_cur.kind != K_ABORT));
          if (mon_cur.kind == K_ABORT) chk("abort_trig_cycles", 64'(mon_tc), 64'(mon_cur.abort_k));
          mon_have = 0;
        end
        mon_pg = gnt; mon_pt = tmr_trig; mon_pb = busy; mon_pp = tmr_pulse;
      end
    end
  end

  // Requester behaviour: drop on done/err, or abort mid-RUN when configured.
  task automatic tick();
    @(negedge clk);
    if (rst) begin
      for (int i = 0; i < R; i++)
        if (req[i] && (done[i] || err[i])) req[i] = 1'b0;
      for (int i = 0; i < R; i++)
        if (req[i] && gnt[i] && tmr_trig && abort_k[i] != 0) begin
          drv_cnt[i]++;
          if (drv_cnt[i] == abort_k[i]) req[i] = 1'b0;
        end
    end
  endtask

  // Modes: 0 normal, 1 early pulse, 2 hung timer, 3 pulse at watchdog limit,
  // 4 abort, 5 abort in the same cycle as the pulse.
  task automatic run_round(input logic [R-1:0] mask);
    int start, last, cyc, kind;
    for (int i = 0; i < R; i++) begin
      if ((cfg_mode[i] == 4 || cfg_mode[i] == 5) && cfg_load[i] < 2)
        cfg_load[i] = $urandom_range(2, 31);
      hang[i] = 0; abort_k[i] = 0; drv_cnt[i] = 0; tgt[i] = cfg_load[i];
      case (cfg_mode[i])
        1: tgt[i] = $urandom_range(1, cfg_load[i] + WDOG);
        2: hang[i] = 1;
        3: tgt[i] = cfg_load[i] + WDOG;
        4: begin hang[i] = 1; abort_k[i] = $urandom_range(2, cfg_load[i]); end
        5: begin abort_k[i] = $urandom_range(2, cfg_load[i]); tgt[i] = abort_k[i] - 1; end
        default: ;
      endcase
      load_in[i*N +: N] = N'(cfg_load[i]);
    end
    start = model_ptr;
    last  = model_ptr;
    for (int k = 0; k < R; k++) begin
      int w;
      w = (start + k) % R;
      if (mask[w]) begin
        if (cfg_load[w] == 0)      kind = K_DONE;
        else if (cfg_mode[w] == 2) kind = K_ERR;
        else if (cfg_mode[w] == 4) kind = K_ABORT;
        else                       kind = K_DONE;
        exp_q.push_back('{idx: w, load: cfg_load[w], kind: kind, abort_k: abort_k[w]});
        last = w;
      end
    end
    model_ptr = (last + 1) % R;
    req = mask;
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!(req == '0 && !busy && exp_q.size() == 0 && !mon_have) && cyc < 3000);
    if (cyc >= 3000) begin
      total++; bad++;
      $display("FAIL round_timeout: got %0d pending slots expected 0", exp_q.size());
      req = '0;
      exp_q.delete();
      repeat (60) tick();
    end
  endtask

  task automatic set_cfg(input int l0, l1, l2, l3, input int m0, m1, m2, m3);
    cfg_load[0] = l0; cfg_load[1] = l1; cfg_load[2] = l2; cfg_load[3] = l3;
    cfg_mode[0] = m0; cfg_mode[1] = m1; cfg_mode[2] = m2; cfg_mode[3] = m3;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, 64'(gnt), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_tmr_load"}, 64'(tmr_load), 64'd0);
    chk({tag, "_tmr_trig"}, 64'(tmr_trig), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < R; i++) begin
      tgt[i] = 1; hang[i] = 0; abort_k[i] = 0; drv_cnt[i] = 0;
    end
    repeat (3) tick();
    chk_all_zero("reset");
    rst = 1'b1;
    repeat (2) tick();

    set_cfg(3, 5, 7, 9, 0, 0, 0, 0);  run_round(4'b1111);
    set_cfg(4, 0, 0, 0, 0, 0, 0, 0);  run_round(4'b0001);
    set_cfg(0, 0, 0, 0, 0, 0, 0, 0);  run_round(4'b0100);
    set_cfg(6, 2, 0, 4, 0, 1, 0, 2);  run_round(4'b1011);
    set_cfg(0, 10, 0, 0, 0, 4, 0, 0); run_round(4'b0010);
    set_cfg(4, 0, 0, 0, 3, 0, 0, 0);  run_round(4'b0001);
    set_cfg(0, 0, 6, 0, 0, 0, 5, 0);  run_round(4'b0100);

    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < R; i++) begin
        cfg_load[i] = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 31));
        cfg_mode[i] = $urandom_range(0, 5);
      end
      run_round(R'($urandom_range(1, 15)));
    end

    // Asynchronous reset in the middle of a hung slot owned by requester 2.
    set_cfg(0, 0, 20, 0, 0, 0, 2, 0);
    hang[2] = 1; abort_k[2] = 0; load_in[2*N +: N] = N'(20);
    exp_q.push_back('{idx: 2, load: 20, kind: K_ERR, abort_k: 0});
    req = 4'b0100;
    begin
      int cyc;
      cyc = 0;
      while (!tmr_trig && cyc < 10) begin tick(); cyc++; end
      chk("reset_test_trig_seen", 64'(tmr_trig), 64'd1);
    end
    repeat (3) tick();
    @(posedge clk);
    #2 rst = 1'b0;
    #1 chk_all_zero("async_reset");
    req = '0;
    exp_q.delete();
    model_ptr = 0;
    repeat (3) tick();
    rst = 1'b1;
    repeat (2) tick();
    set_cfg(3, 4, 5, 6, 0, 0, 0, 0);  run_round(4'b1111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: got time %0t expected finish earlier", $time);
    $fatal(1, "simulation time limit");
  end

endmodule
